acq_sequencer: RTL and testbench

Acquisition sequencer that sits directly downstream of the host command controller. It consumes the `cpu_trig` start pulse and the `repetitions`, `samples` and `generator_hops` configuration words. It then runs the nested measurement loop: for each repetition, for each generator hop, fire a hop trigger, wait a settle time, then capture `samples` ADC words. Captured words go to the downstream buffer, tagged with loop indices, and the block reports busy/done status back to the host side.

---
 rtl/acq_pkg.sv | 15 +
 rtl/settle_timer.sv | 30 +++
 rtl/acq_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_acq_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer.
package acq_pkg;

  // Loop-count width; matches the controller's 24-bit configuration words.
  localparam int CNT_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOP    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ACQ    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags the last cycle of the settle wait.
module settle_timer #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int TW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [TW-1:0] count;

  // Load the full wait on a hop, then count down while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(SETTLE_CYCLES);
    end else if (en && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  // Terminal count: the cycle holding 1 is the last settle cycle.
  assign expired = (count <= TW'(1));

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: repetition x hop x sample loop with hop triggers,
// settle wait, ADC capture and busy/done reporting.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for cpu_trig; indices hold last values
//   HOP    | hop_trig pulse, settle timer loaded
//   SETTLE | waiting for the generator to settle; adc_valid ignored
//   ACQ    | capturing adc_data on adc_valid until samples words per hop
//   DONE   | run complete; done pulses on the exit edge, busy drops
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_trig,
  input  logic              abort,
  input  logic [CNT_W-1:0]  repetitions,
  input  logic [CNT_W-1:0]  samples,
  input  logic [CNT_W-1:0]  generator_hops,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              hop_trig,
  output logic              sample_we,
  output logic [DATA_W-1:0] sample_data,
  output logic [CNT_W-1:0]  rep_idx,
  output logic [CNT_W-1:0]  hop_idx,
  output logic [CNT_W-1:0]  sample_idx,
  output logic              busy,
  output logic              done
);

  state_t state, state_nxt;

  logic [CNT_W-1:0] reps_q, samp_q, hops_q;
  logic [CNT_W-1:0] rep_cnt, hop_cnt, smp_cnt;

  logic trig_accept;
  logic zero_cfg;
  logic capture;
  logic last_smp, last_hop, last_rep;
  logic timer_load, timer_en, timer_expired;

  assign trig_accept = (state == ST_IDLE) && cpu_trig && !abort;
  assign zero_cfg    = (repetitions == '0) || (samples == '0) || (generator_hops == '0);

  // Counts are never zero once past IDLE, so count-1 cannot underflow.
  assign last_smp = (smp_cnt == samp_q - CNT_W'(1));
  assign last_hop = (hop_cnt == hops_q - CNT_W'(1));
  assign last_rep = (rep_cnt == reps_q - CNT_W'(1));

  assign hop_trig = (state == ST_HOP);

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state strobes; abort wins over everything outside IDLE.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig_accept) begin
          state_nxt = zero_cfg ? ST_DONE : ST_HOP;
        end
      end
      ST_HOP: begin
        timer_load = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (SETTLE_CYCLES == 0) begin
          state_nxt = ST_ACQ;
        end else begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        timer_en = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (timer_expired) begin
          state_nxt = ST_ACQ;
        end
      end
      ST_ACQ: begin
        capture = adc_valid;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (adc_valid && last_smp) begin
          state_nxt = (last_hop && last_rep) ? ST_DONE : ST_HOP;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Busy spans trigger acceptance to run end; done pulses on leaving DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (trig_accept) begin
        busy <= 1'b1;
      end else if ((state != ST_IDLE) && abort) begin
        busy <= 1'b0;
      end else if (state == ST_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // Shadow configuration and nested loop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reps_q  <= '0;
      samp_q  <= '0;
      hops_q  <= '0;
      rep_cnt <= '0;
      hop_cnt <= '0;
      smp_cnt <= '0;
    end else if (trig_accept) begin
      reps_q  <= repetitions;
      samp_q  <= samples;
      hops_q  <= generator_hops;
      rep_cnt <= '0;
      hop_cnt <= '0;
      smp_cnt <= '0;
    end else if (capture && !abort) begin
      if (last_smp) begin
        smp_cnt <= '0;
        if (!last_hop) begin
          hop_cnt <= hop_cnt + CNT_W'(1);
        end else if (!last_rep) begin
          hop_cnt <= '0;
          rep_cnt <= rep_cnt + CNT_W'(1);
        end
      end else begin
        smp_cnt <= smp_cnt + CNT_W'(1);
      end
    end
  end

  // Registered capture path; indices shown are those of the word being strobed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_we   <= 1'b0;
      sample_data <= '0;
      rep_idx     <= '0;
      hop_idx     <= '0;
      sample_idx  <= '0;
    end else begin
      sample_we <= capture;
      if (capture) begin
        sample_data <= adc_data;
        rep_idx     <= rep_cnt;
        hop_idx     <= hop_cnt;
        sample_idx  <= smp_cnt;
      end else if (trig_accept) begin
        rep_idx    <= '0;
        hop_idx    <= '0;
        sample_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Scoreboard bench for acq_sequencer: a loop-level model predicts the cycle
// of every hop trigger, captured word and done pulse; a monitor pops and
// compares as the DUT presents them.
module tb_acq_sequencer;

  localparam int SETTLE = 2;

  typedef struct {
    int          cyc;
    int          r;
    int          h;
    int          n;
    logic [15:0] d;
  } samp_t;

  logic        clk;
  logic        rst_n;
  logic        cpu_trig;
  logic        abort;
  logic [23:0] repetitions;
  logic [23:0] samples;
  logic [23:0] generator_hops;
  logic        adc_valid;
  logic [15:0] adc_data;
  logic        hop_trig;
  logic        sample_we;
  logic [15:0] sample_data;
  logic [23:0] rep_idx;
  logic [23:0] hop_idx;
  logic [23:0] sample_idx;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int busy_lo = 0;
  int busy_hi = 0;

  samp_t exp_s[$];
  int    exp_h[$];
  int    exp_d[$];

  acq_sequencer #(
    .DATA_W        (16),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_trig       (cpu_trig),
    .abort          (abort),
    .repetitions    (repetitions),
    .samples        (samples),
    .generator_hops (generator_hops),
    .adc_valid      (adc_valid),
    .adc_data       (adc_data),
    .hop_trig       (hop_trig),
    .sample_we      (sample_we),
    .sample_data    (sample_data),
    .rep_idx        (rep_idx),
    .hop_idx        (hop_idx),
    .sample_idx     (sample_idx),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cycle %0d: got event expected none", nm, cyc);
  endtask

  // Monitor: sample outputs mid-cycle and check them against the scoreboard.
  always @(negedge clk) begin
    samp_t e;
    int    c;
    chk("busy", busy, (cyc >= busy_lo) && (cyc < busy_hi));
    if (sample_we) begin
      if (exp_s.size() == 0) begin
        unexpected("sample_we");
      end else begin
        e = exp_s.pop_front();
        chk("sample_cycle", cyc, e.cyc);
        chk("rep_idx", rep_idx, e.r);
        chk("hop_idx", hop_idx, e.h);
        chk("sample_idx", sample_idx, e.n);
        chk("sample_data", sample_data, e.d);
      end
    end
    if (hop_trig) begin
      if (exp_h.size() == 0) begin
        unexpected("hop_trig");
      end else begin
        c = exp_h.pop_front();
        chk("hop_cycle", cyc, c);
      end
    end
    if (done) begin
      if (exp_d.size() == 0) begin
        unexpected("done");
      end else begin
        c = exp_d.pop_front();
        chk("done_cycle", cyc, c);
      end
    end
  end

  task automatic check_drained(input string tag);
    chk({tag, "_hops_left"}, exp_h.size(), 0);
    chk({tag, "_samples_left"}, exp_s.size(), 0);
    chk({tag, "_done_left"}, exp_d.size(), 0);
    exp_h.delete();
    exp_s.delete();
    exp_d.delete();
  endtask

  // One run: predict all events from the loop rules, then drive the stimulus.
  // vpct < 0 selects a fixed 1-in-3 adc_valid pattern.
  task automatic run(input int reps, input int hops, input int samps,
                     input int vpct, input int chg_at, input bit do_abort);
    bit          vq[$];
    logic [15:0] dq[$];
    samp_t       e;
    int          t0, pos, i, n, abort_idx, end_idx, lr, lh, ln;
    bit          stop;
    t0 = cyc;
    pos = 1;
    abort_idx = -1;
    stop = 1'b0;
    lr = 0; lh = 0; ln = 0;
    if (reps > 0 && hops > 0 && samps > 0) begin
      for (int r = 0; r < reps && !stop; r++) begin
        for (int h = 0; h < hops && !stop; h++) begin
          exp_h.push_back(t0 + pos);
          i = pos + 1 + SETTLE;
          n = 0;
          while (n < samps && !stop) begin
            while (vq.size() <= i) begin
              vq.push_back((vpct < 0) ? (vq.size() % 3 == 0) : ($urandom_range(0, 99) < vpct));
              dq.push_back(16'($urandom_range(0, 65535)));
            end
            if (vq[i]) begin
              e.cyc = t0 + i + 1;
              e.r = r; e.h = h; e.n = n; e.d = dq[i];
              exp_s.push_back(e);
              lr = r; lh = h; ln = n;
              if (do_abort && r == 0 && h == 1 && n == 2) begin
                stop = 1'b1;
                abort_idx = i;
              end
              n++;
            end
            i++;
          end
          pos = i;
        end
      end
    end
    if (!stop) exp_d.push_back(t0 + pos + 1);
    busy_lo = t0 + 1;
    busy_hi = stop ? (t0 + abort_idx + 1) : (t0 + pos + 1);
    end_idx = stop ? (abort_idx + 4) : (pos + 4);

    repetitions    = 24'(reps);
    samples        = 24'(samps);
    generator_hops = 24'(hops);
    for (int k = 0; k <= end_idx; k++) begin
      while (vq.size() <= k) begin
        vq.push_back((vpct < 0) ? (vq.size() % 3 == 0) : ($urandom_range(0, 99) < vpct));
        dq.push_back(16'($urandom_range(0, 65535)));
      end
      cpu_trig  = (k == 0) || (k == chg_at);
      if (k == chg_at) samples = 24'd9;
      abort     = (k == abort_idx);
      adc_valid = vq[k];
      adc_data  = dq[k];
      @(posedge clk);
      #1;
    end
    cpu_trig  = 1'b0;
    abort     = 1'b0;
    adc_valid = 1'b0;
    check_drained("run");
    chk("rep_idx_hold", rep_idx, lr);
    chk("hop_idx_hold", hop_idx, lh);
    chk("sample_idx_hold", sample_idx, ln);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_hop_trig"}, hop_trig, 0);
    chk({tag, "_sample_we"}, sample_we, 0);
    chk({tag, "_sample_data"}, sample_data, 0);
    chk({tag, "_rep_idx"}, rep_idx, 0);
    chk({tag, "_hop_idx"}, hop_idx, 0);
    chk({tag, "_sample_idx"}, sample_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Reset asserted in the first SETTLE cycle of a run.
  task automatic reset_mid_settle();
    int t0;
    t0 = cyc;
    repetitions = 24'd1; samples = 24'd3; generator_hops = 24'd1;
    exp_h.push_back(t0 + 1);
    busy_lo = t0 + 1;
    busy_hi = t0 + 2;
    cpu_trig = 1'b1;
    @(posedge clk); #1;
    cpu_trig = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_drained("rst_mid");
  endtask

  // Abort in IDLE must swallow a simultaneous trigger.
  task automatic idle_abort();
    busy_lo = 0;
    busy_hi = 0;
    repetitions = 24'd1; samples = 24'd2; generator_hops = 24'd1;
    cpu_trig = 1'b1;
    abort    = 1'b1;
    @(posedge clk); #1;
    cpu_trig = 1'b0;
    abort    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_abort_busy", busy, 0);
    check_drained("idle_abort");
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_trig = 1'b0;
    abort = 1'b0;
    repetitions = '0;
    samples = '0;
    generator_hops = '0;
    adc_valid = 1'b0;
    adc_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(2, 3, 4, 100, -1, 1'b0);
    run(5, 5, 0, 100, -1, 1'b0);
    run(0, 2, 2, 100, -1, 1'b0);
    run(3, 0, 1, 100, -1, 1'b0);
    run(1, 2, 3, -1, -1, 1'b0);
    run(2, 2, 4, 70, 8, 1'b0);
    run(2, 3, 4, 100, -1, 1'b1);
    run(1, 1, 2, 100, -1, 1'b0);
    reset_mid_settle();
    run(1, 2, 2, 100, -1, 1'b0);
    idle_abort();
    for (int it = 0; it < 6; it++) begin
      run(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
          int'($urandom_range(1, 5)), int'($urandom_range(30, 100)), -1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
